// File: rtl/nor_gate_core_if.sv
// Bundle for nor_gate_core operands, enable and result views.
// Optional par_q appears only when NOR_GATE_PARITY_EN is defined.
interface nor_gate_core_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             en;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] c_q;
  logic             c_q_valid;
  logic             all_ones;
  logic [CNT_W-1:0] ones_cnt;
  logic             ones_sat;
`ifdef NOR_GATE_PARITY_EN
  logic             par_q;

  modport master (
    output a, b, en,
    input  c, c_q, c_q_valid, all_ones,
    input  ones_cnt, ones_sat, par_q
  );

  modport slave (
    input  a, b, en,
    output c, c_q, c_q_valid, all_ones,
    output ones_cnt, ones_sat, par_q
  );
`else
  modport master (
    output a, b, en,
    input  c, c_q, c_q_valid, all_ones,
    input  ones_cnt, ones_sat
  );

  modport slave (
    input  a, b, en,
    output c, c_q, c_q_valid, all_ones,
    output ones_cnt, ones_sat
  );
`endif
endinterface

// File: rtl/nor_gate_core.sv
// Bitwise NOR with registered copy and saturating all-ones counter.
// Define NOR_GATE_PARITY_EN to add the registered parity output par_q.
module nor_gate_core #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  nor_gate_core_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] w_c;
  logic             w_all_ones;

  logic [WIDTH-1:0] r_c_q;
  logic             r_c_q_valid;
  logic [CNT_W-1:0] r_ones_cnt;
  logic             r_ones_sat;

  assign w_c        = ~(bus.a | bus.b);
  assign w_all_ones = &w_c;

  // Saturation flag is registered with the counter so it never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c_q       <= '0;
      r_c_q_valid <= 1'b0;
      r_ones_cnt  <= '0;
      r_ones_sat  <= 1'b0;
    end else if (bus.en) begin
      r_c_q       <= w_c;
      r_c_q_valid <= 1'b1;
      if (w_all_ones && !r_ones_sat) begin
        r_ones_cnt <= r_ones_cnt + CNT_ONE;
        r_ones_sat <= (r_ones_cnt == (CNT_MAX - CNT_ONE));
      end
    end
  end

  assign bus.c         = w_c;
  assign bus.all_ones  = w_all_ones;
  assign bus.c_q       = r_c_q;
  assign bus.c_q_valid = r_c_q_valid;
  assign bus.ones_cnt  = r_ones_cnt;
  assign bus.ones_sat  = r_ones_sat;

`ifdef NOR_GATE_PARITY_EN
  logic r_par_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_q <= 1'b0;
    end else if (bus.en) begin
      r_par_q <= ^w_c;
    end
  end

  assign bus.par_q = r_par_q;
`endif

endmodule

// File: tb/tb_nor_gate_core.sv
// Directed bench for nor_gate_core: WIDTH=1 gate and WIDTH=4/CNT_W=3.
// Parity checks run only when NOR_GATE_PARITY_EN is defined.
module tb_nor_gate_core;

  logic clk;
  logic rst;

  int n_chk;
  int n_fail;

  nor_gate_core_if #(.WIDTH(1), .CNT_W(16)) bus1 ();
  nor_gate_core_if #(.WIDTH(4), .CNT_W(3))  bus4 ();

  nor_gate_core #(.WIDTH(1), .CNT_W(16)) u_d1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  nor_gate_core #(.WIDTH(4), .CNT_W(3)) u_d4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  logic [1:0] ab_vec [4];
  logic       c_exp  [4];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    ab_vec[0] = 2'b00; c_exp[0] = 1'b1;
    ab_vec[1] = 2'b01; c_exp[1] = 1'b0;
    ab_vec[2] = 2'b10; c_exp[2] = 1'b0;
    ab_vec[3] = 2'b11; c_exp[3] = 1'b0;

    rst     = 1'b1;
    bus1.a  = '0;
    bus1.b  = '0;
    bus1.en = 1'b0;
    bus4.a  = '0;
    bus4.b  = '0;
    bus4.en = 1'b0;
    #1;
    check("rst_c1",     64'(bus1.c), 64'(1));
    check("rst_cq1",    64'(bus1.c_q), 64'(0));
    check("rst_vld1",   64'(bus1.c_q_valid), 64'(0));
    check("rst_cnt1",   64'(bus1.ones_cnt), 64'(0));
    check("rst_sat1",   64'(bus1.ones_sat), 64'(0));
    check("rst_cnt4",   64'(bus4.ones_cnt), 64'(0));

    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      bus1.a = ab_vec[i][1];
      bus1.b = ab_vec[i][0];
      #5;
      check($sformatf("en0_c[%0d]", i), 64'(bus1.c), 64'(c_exp[i]));
      check($sformatf("en0_cq[%0d]", i), 64'(bus1.c_q), 64'(0));
      check($sformatf("en0_vld[%0d]", i), 64'(bus1.c_q_valid), 64'(0));
    end

    @(negedge clk);
    bus1.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus1.a = ab_vec[i][1];
      bus1.b = ab_vec[i][0];
      @(posedge clk);
      #1;
      check($sformatf("en1_cq[%0d]", i), 64'(bus1.c_q), 64'(c_exp[i]));
      check($sformatf("en1_vld[%0d]", i), 64'(bus1.c_q_valid), 64'(1));
      @(negedge clk);
    end
    bus1.en = 1'b0;
    check("w1_cnt_end", 64'(bus1.ones_cnt), 64'(1));
    check("w1_sat_end", 64'(bus1.ones_sat), 64'(0));

    bus4.a = 4'b1010;
    bus4.b = 4'b0101;
    #1;
    check("w4_c_0",    64'(bus4.c), 64'(4'b0000));
    check("w4_all_0",  64'(bus4.all_ones), 64'(0));
    bus4.a = 4'b0000;
    bus4.b = 4'b0000;
    #1;
    check("w4_c_f",    64'(bus4.c), 64'(4'b1111));
    check("w4_all_1",  64'(bus4.all_ones), 64'(1));
    bus4.a = 4'b0110;
    bus4.b = 4'b1000;
    #1;
    check("w4_c_1",    64'(bus4.c), 64'(4'b0001));

    @(negedge clk);
    bus4.en = 1'b1;
    @(posedge clk);
    #1;
    check("w4_cq_1",   64'(bus4.c_q), 64'(4'b0001));
    check("w4_cnt_nz", 64'(bus4.ones_cnt), 64'(0));

    @(negedge clk);
    bus4.a = 4'b0000;
    bus4.b = 4'b0000;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("pre_cnt[%0d]", k), 64'(bus4.ones_cnt), 64'(k));
    end

    #2;
    rst    = 1'b1;
    bus4.a = 4'b0011;
    #1;
    check("mid_cnt",  64'(bus4.ones_cnt), 64'(0));
    check("mid_cq",   64'(bus4.c_q), 64'(0));
    check("mid_vld",  64'(bus4.c_q_valid), 64'(0));
    check("mid_sat",  64'(bus4.ones_sat), 64'(0));
    check("mid_c",    64'(bus4.c), 64'(4'b1100));
    check("mid_vld1", 64'(bus1.c_q_valid), 64'(0));
    check("mid_cnt1", 64'(bus1.ones_cnt), 64'(0));
    @(posedge clk);
    #1;
    check("rst_dom",  64'(bus4.c_q_valid), 64'(0));

    @(negedge clk);
    rst    = 1'b0;
    bus4.a = 4'b0000;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("cnt[%0d]", k), 64'(bus4.ones_cnt),
            64'((k < 7) ? k : 7));
      check($sformatf("sat[%0d]", k), 64'(bus4.ones_sat),
            64'((k >= 7) ? 1 : 0));
    end

    @(negedge clk);
    bus4.en = 1'b0;
    bus4.a  = 4'b1001;
    @(posedge clk);
    #1;
    check("hold_cnt", 64'(bus4.ones_cnt), 64'(7));
    check("hold_cq",  64'(bus4.c_q), 64'(4'b1111));
    check("hold_vld", 64'(bus4.c_q_valid), 64'(1));

`ifdef NOR_GATE_PARITY_EN
    @(negedge clk);
    bus4.en = 1'b1;
    bus4.a  = 4'b0001;
    bus4.b  = 4'b0000;
    @(posedge clk);
    #1;
    check("par_c",  64'(bus4.c), 64'(4'b1110));
    check("par_q1", 64'(bus4.par_q), 64'(1));
    @(negedge clk);
    bus4.a = 4'b0000;
    @(posedge clk);
    #1;
    check("par_q0", 64'(bus4.par_q), 64'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nor_gate_core.md
Name: nor_gate_core

Overview:
Parameterised bitwise 2-input NOR primitive for the basic-gate library. It provides a purely combinational NOR output and a registered copy of that output. A saturating counter records how many enabled cycles produced an all-ones NOR result, which is useful for stuck-input detection. It is used wherever a gate-level NOR with a registered view and simple statistics is needed.

Parameters:
WIDTH, 1, bit width of operands a, b and result c (legal range 1..64)
CNT_W, 16, width of the saturating all-ones event counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
a  input  WIDTH  operand A
b  input  WIDTH  operand B
en  input  1  capture enable for registered output and counter
c  output  WIDTH  combinational result, ~(a | b)
c_q  output  WIDTH  registered copy of c
c_q_valid  output  1  high once c_q holds a captured value
all_ones  output  1  combinational, high when c is all ones (a and b both all zero)
ones_cnt  output  CNT_W  saturating count of enabled cycles with all_ones high
ones_sat  output  1  high when ones_cnt equals its maximum, 2^CNT_W-1

Behaviour:
- Combinational path:
  - c = ~(a | b), bit by bit, with zero latency.
  - c is independent of clk, rst and en.
  - c reflects a and b even while rst is asserted.
- all_ones = &c, combinational.
- Reset:
  - rst asserted, at any time and without waiting for a clock edge: c_q = 0, c_q_valid = 0, ones_cnt = 0, ones_sat = 0.
  - Reset dominates en.
  - Deassertion is released on the next rising clk edge.
- Rising clk with rst low and en = 1:
  - c_q <= c.
  - c_q_valid <= 1.
  - If all_ones is high, ones_cnt increments by 1, saturating at 2^CNT_W-1 with no wrap.
- Rising clk with en = 0: c_q, c_q_valid and ones_cnt hold their values.
- ones_sat = (ones_cnt == all-ones), registered-derived and glitch-free.
- c_q has 1-cycle latency relative to a/b sampled at the enabled edge.
- X/Z on a or b is not sanitised; it propagates per standard Verilog semantics.
- With WIDTH = 1 the block is a plain NOR gate on c. Truth table:
  - 00 -> 1
  - 01 -> 0
  - 10 -> 0
  - 11 -> 0

Optional Feature:
NOR_GATE_PARITY_EN
- Defined:
  - Adds output port par_q (1 bit).
  - On each enabled rising edge, par_q <= ^c (XOR reduction of the NOR result).
  - par_q is reset to 0 by rst.
- Undefined: port par_q is absent and no parity logic is generated.
- All other behaviour is identical in both builds.

Test Plan:
- WIDTH=1, rst pulse, then apply ab = 00, 01, 10, 11, 5 time units each, en=0 -> c = 1, 0, 0, 0 immediately; c_q=0 and c_q_valid=0 throughout.
- WIDTH=1, en=1, same sequence with one clk edge per vector -> c_q follows 1, 0, 0, 0 one cycle later; ones_cnt=1 at the end.
- WIDTH=4, a=4'b1010, b=4'b0101 -> c=0000, all_ones=0. Then a=0, b=0 -> c=1111, all_ones=1.
- CNT_W=3, a=b=0, en=1 for 10 cycles -> ones_cnt climbs 1..7 and holds at 7; ones_sat=1 from the 7th edge.
- Assert rst mid-count between clock edges -> ones_cnt, c_q and c_q_valid go to 0 immediately, before the next edge, while c still tracks the inputs.
- With NOR_GATE_PARITY_EN defined, WIDTH=4, a=4'b0001, b=0, en=1 -> c=1110, par_q=1 after the edge. Then a=0, b=0 -> par_q=0.
